// File: rtl/pwm_event_sequencer.sv
// pwm_event_sequencer: time-addressed PWM engine replaying a host-written (timestamp, pattern) table.
module pwm_event_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              addr_strobe_i,
    input  logic              data_strobe_i,
    input  logic              ram_write_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              run_i,
    input  logic [DATA_W-1:0] terminate_i,
    output logic [DATA_W-1:0] pwm_o,
    output logic              busy_o,
    output logic              wrap_o
);
    localparam int E_W = ADDR_W - 1;
    localparam logic [E_W-1:0] E_LAST = '1;

    typedef enum logic [2:0] {IDLE, FETCH_T, FETCH_P, WAIT, DONE} state_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] t_q, p_q, data_q;
    logic [DATA_W-1:0] cnt_q, cnt_d, pwm_q, pwm_d;
    logic [E_W-1:0]    e_q, e_d;
    logic              wrap_q, wrap_d;
    state_t            state_q, state_d;

    // Table storage is never reset; the sequencer reads see pre-write data on a collision.
    always_ff @(posedge clk_i) begin
        if (data_strobe_i && ram_write_i) mem[addr_i] <= data_i;
        if (state_q == FETCH_T) t_q <= mem[{e_q, 1'b0}];
        if (state_q == FETCH_P) p_q <= mem[{e_q, 1'b1}];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            e_q     <= '0;
            pwm_q   <= '0;
            wrap_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            pwm_q   <= pwm_d;
            wrap_q  <= wrap_d;
            if (addr_strobe_i) data_q <= mem[addr_i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + DATA_W'(1);
        e_d     = e_q;
        pwm_d   = pwm_q;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                e_d     = '0;
                pwm_d   = '0;
                state_d = run_i ? FETCH_T : IDLE;
            end
            FETCH_T: state_d = FETCH_P;
            FETCH_P: state_d = &t_q ? DONE : WAIT;
            WAIT: if (cnt_q >= t_q) begin
                pwm_d   = p_q;
                e_d     = (e_q == E_LAST) ? e_q : e_q + E_W'(1);
                state_d = (e_q == E_LAST) ? DONE : FETCH_T;
            end
            default: ;
        endcase
        // Period restart wins over any fetch/wait transition, but a firing event still lands.
        if (state_q != IDLE && terminate_i != '0 && cnt_q == terminate_i) begin
            cnt_d   = '0;
            e_d     = '0;
            wrap_d  = 1'b1;
            state_d = FETCH_T;
        end
        if (!run_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            e_d     = '0;
            pwm_d   = '0;
            wrap_d  = 1'b0;
        end
    end

    assign data_o = data_q;
    assign pwm_o  = pwm_q;
    assign wrap_o = wrap_q;
    assign busy_o = (state_q != IDLE);
endmodule
